// File: rtl/dmem_responder_if.sv
// Data-memory port bundle: request and response handshakes between the core and its data memory.
interface dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: one outstanding request, serviced after LATENCY wait cycles.
// Optional feature: define DMEM_MISALIGN_CHK_EN to flag non-word-aligned addresses as errors.
module dmem_responder #(
  parameter int unsigned DEPTH   = 256,
  parameter int unsigned LATENCY = 2
) (
  input logic             clk,
  input logic             rst,
  dmem_responder_if.slave bus
);
  localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q;
  logic [31:0] addr_q, wdata_q;
  logic [31:0] rdata_q;
  logic        err_q;
  logic [31:0] mem [DEPTH];

  logic            accept, go_resp;
  logic            acc_we, acc_err;
  logic [31:0]     acc_addr, acc_wdata;
  logic [IdxW-1:0] acc_idx;

  assign bus.req_ready = rst & (state_q == StIdle);
  assign bus.rsp_valid = (state_q == StResp);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;
  assign accept        = bus.req_valid & bus.req_ready;

  // With LATENCY=0 the access happens on the acceptance edge, so use the live request then.
  always_comb begin
    acc_we    = we_q;
    acc_addr  = addr_q;
    acc_wdata = wdata_q;
    if (state_q == StIdle) begin
      acc_we    = bus.req_we;
      acc_addr  = bus.req_addr;
      acc_wdata = bus.req_wdata;
    end
  end

  assign acc_idx = acc_addr[IdxW+1:2];

`ifdef DMEM_MISALIGN_CHK_EN
  assign acc_err = (acc_addr[31:2] >= 30'(DEPTH)) | (acc_addr[1:0] != 2'b00);
`else
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^acc_addr[1:0];
  assign acc_err = (acc_addr[31:2] >= 30'(DEPTH));
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    go_resp = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          cnt_d = 4'd0;
          if (LATENCY == 0) begin
            state_d = StResp;
            go_resp = 1'b1;
          end else begin
            state_d = StWait;
          end
        end
      end
      StWait: begin
        if (cnt_q == 4'(LATENCY - 1)) begin
          state_d = StResp;
          go_resp = 1'b1;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      StResp: begin
        if (bus.rsp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        we_q    <= bus.req_we;
        addr_q  <= bus.req_addr;
        wdata_q <= bus.req_wdata;
      end
      if (go_resp) begin
        err_q   <= acc_err;
        rdata_q <= (acc_we | acc_err) ? 32'd0 : mem[acc_idx];
      end
    end
  end

  // Storage is never cleared; a reset on the commit edge suppresses the write.
  always_ff @(posedge clk) begin
    if (rst && go_resp && acc_we && !acc_err) mem[acc_idx] <= acc_wdata;
  end
endmodule

// File: tb/tb_dmem_responder.sv
// Randomized bench for dmem_responder against an array-based memory model.
module tb_dmem_responder;
  localparam int unsigned Depth = 256;
  localparam int unsigned Lat   = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad   = 0;
  logic [31:0] model [Depth];

  dmem_responder_if bus();

  dmem_responder #(
    .DEPTH  (Depth),
    .LATENCY(Lat)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Full request/response transaction; expectations come from the model.
  task automatic do_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input int hold, input string tag);
    logic        exp_err;
    logic [31:0] exp_rd;
    logic [31:0] held;
    int          n;
    exp_err = (addr[31:2] >= 30'(Depth));
`ifdef DMEM_MISALIGN_CHK_EN
    exp_err = exp_err | (addr[1:0] != 2'b00);
`endif
    exp_rd = (we || exp_err) ? 32'd0 : model[addr[9:2]];
    if (we && !exp_err) model[addr[9:2]] = wdata;

    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    n = 0;
    while (!bus.req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (bus.req_ready !== 1'b1) begin
      check({tag, ":req_ready_timeout"}, 32'(bus.req_ready), 32'd1);
      bus.req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (!bus.rsp_valid) check({tag, ":busy_ready"}, 32'(bus.req_ready), 32'd0);
      // Junk on the request side must be ignored while busy.
      bus.req_valid = 1'($urandom);
      bus.req_we    = 1'($urandom);
      bus.req_addr  = $urandom;
      bus.req_wdata = $urandom;
    end while (!bus.rsp_valid && n < 20);
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    check({tag, ":latency"}, 32'(n), 32'(Lat + 1));
    check({tag, ":rdata"}, bus.rsp_rdata, exp_rd);
    check({tag, ":err"}, 32'(bus.rsp_err), 32'(exp_err));
    check({tag, ":resp_ready"}, 32'(bus.req_ready), 32'd0);
    held = bus.rsp_rdata;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, ":hold_valid"}, 32'(bus.rsp_valid), 32'd1);
      check({tag, ":hold_rdata"}, bus.rsp_rdata, held);
      check({tag, ":hold_ready"}, 32'(bus.req_ready), 32'd0);
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    check({tag, ":done_valid"}, 32'(bus.rsp_valid), 32'd0);
    check({tag, ":done_ready"}, 32'(bus.req_ready), 32'd1);
  endtask

  initial begin
    logic [31:0] addr;
    int          r;
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    bus.req_addr  = 32'd0;
    bus.req_wdata = 32'd0;
    bus.rsp_ready = 1'b0;

    // Reset held for two cycles with a request pending.
    repeat (2) @(negedge clk);
    check("rst_req_ready", 32'(bus.req_ready), 32'd0);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_rdata", bus.rsp_rdata, 32'd0);
    check("rst_err", 32'(bus.rsp_err), 32'd0);
    bus.req_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("post_rst_ready", 32'(bus.req_ready), 32'd1);

    for (int i = 0; i < int'(Depth); i++) do_txn(1'b1, 32'(i * 4), $urandom, 0, "preload");

    do_txn(1'b1, 32'h10, 32'hDEADBEEF, 0, "wr10");
    do_txn(1'b0, 32'h10, 32'h0, 0, "rd10");
    do_txn(1'b0, 32'h10, 32'h0, 5, "bp10");
    do_txn(1'b1, 32'h400, 32'h1234, 0, "wr_range");
    do_txn(1'b0, 32'h0, 32'h0, 0, "rd0");
    do_txn(1'b0, 32'h11, 32'h0, 1, "rd_mis");
    do_txn(1'b1, 32'h23, 32'hA5A5A5A5, 0, "wr_mis");
    do_txn(1'b0, 32'h20, 32'h0, 0, "rd20");
    do_txn(1'b0, 32'h3FC, 32'h0, 0, "rd_top");
    do_txn(1'b0, 32'hFFFF_FFFC, 32'h0, 0, "rd_far");

    // Reset during WAIT abandons the write.
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_addr  = 32'h20;
    bus.req_wdata = 32'h55;
    check("rw_accept_ready", 32'(bus.req_ready), 32'd1);
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rw_no_valid", 32'(bus.rsp_valid), 32'd0);
    end
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rw_idle_valid", 32'(bus.rsp_valid), 32'd0);
      check("rw_idle_ready", 32'(bus.req_ready), 32'd1);
    end
    do_txn(1'b0, 32'h20, 32'h0, 0, "rd20_after_rst");

    for (int t = 0; t < 80; t++) begin
      r = $urandom_range(0, 9);
      addr = 32'($urandom_range(0, Depth - 1)) << 2;
      if (r == 0) addr = 32'h400 + (32'($urandom_range(0, 4000)) << 2);
      if (r == 1) addr = addr | 32'($urandom_range(1, 3));
      do_txn(1'($urandom), addr, $urandom, $urandom_range(0, 3), "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
